// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: response-owner encoding and strobe width.
package sram_port_arbiter_pkg;

    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } own_state_e;

endpackage

// File: rtl/sram_port_arbiter_mux2to1.sv
// Two-input word mux: y = selm ? w : v.
module sram_port_arbiter_mux2to1 #(
    parameter int K = 32
) (
    input  logic [K-1:0] v,
    input  logic [K-1:0] w,
    input  logic         selm,
    output logic [K-1:0] y
);

    assign y = selm ? w : v;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch and data access.
// Data side has priority; a starvation counter forces an I grant after STARVE_MAX D grants.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DW-1:0]     i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [STRB_W-1:0] d_wstrb,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DW-1:0]     d_rdata,
    output logic              sram_en,
    output logic [STRB_W-1:0] sram_wen,
    output logic [AW-1:0]     sram_addr,
    output logic [DW-1:0]     sram_wdata,
    input  logic [DW-1:0]     sram_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    own_state_e  state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        gnt_i, gnt_d;
    logic [AW-1:0] addr_sel;

    sram_port_arbiter_mux2to1 #(.K(AW)) u_addr_mux (
        .v    (i_addr),
        .w    (d_addr),
        .selm (gnt_d),
        .y    (addr_sel)
    );

    always_comb begin
        gnt_d = 1'b0;
        gnt_i = 1'b0;
        // No grant can be issued while reset is held, so nothing is accepted and then lost.
        if (!rst) begin
            gnt_d = d_req & ~(i_req & (starve_cnt_q == STARVE_LIM));
            gnt_i = i_req & ~gnt_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (gnt_i)      state_d = OWN_I;
        else if (gnt_d) state_d = OWN_D;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_req || gnt_i)
            starve_cnt_d = 4'd0;
        else if (gnt_d && starve_cnt_q != STARVE_LIM)
            starve_cnt_d = starve_cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        i_addr_ok  = gnt_i;
        d_addr_ok  = gnt_d;
        sram_en    = gnt_i | gnt_d;
        sram_wen   = (gnt_d & d_wr) ? d_wstrb : '0;
        sram_addr  = rst ? '0 : addr_sel;
        sram_wdata = rst ? '0 : d_wdata;
        i_data_ok  = ~rst & (state_q == OWN_I);
        d_data_ok  = ~rst & (state_q == OWN_D);
        i_rdata    = rst ? '0 : sram_rdata;
        d_rdata    = rst ? '0 : sram_rdata;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with hand-computed expectations.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [31:0] i_addr, d_addr, d_wdata, sram_rdata;
    logic [3:0]  d_wstrb;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, sram_en;
    logic [31:0] i_rdata, d_rdata, sram_addr, sram_wdata;
    logic [3:0]  sram_wen;

    int checks   = 0;
    int failures = 0;

    sram_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_addr_ok  (i_addr_ok),
        .i_data_ok  (i_data_ok),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_wr       (d_wr),
        .d_wstrb    (d_wstrb),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_addr_ok  (d_addr_ok),
        .d_data_ok  (d_data_ok),
        .d_rdata    (d_rdata),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    // Expected contention grant sequence, 1 = D, 0 = I.
    logic [9:0] cont_exp;
    logic [4:0] post_rst_exp;

    initial begin
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_wr = 1'b1; d_wstrb = 4'hF;
        i_addr = 32'h1111_0000; d_addr = 32'h2222_0000; d_wdata = 32'h5555_AAAA;
        sram_rdata = 32'hDEAD_BEEF;
        cont_exp = 10'b1111011110;
        post_rst_exp = 5'b11110;

        tick(); tick(); settle();
        chk("rst_i_addr_ok", {31'd0, i_addr_ok}, 32'd0);
        chk("rst_d_addr_ok", {31'd0, d_addr_ok}, 32'd0);
        chk("rst_sram_en",   {31'd0, sram_en}, 32'd0);
        chk("rst_sram_wen",  {28'd0, sram_wen}, 32'd0);
        chk("rst_sram_addr", sram_addr, 32'd0);
        chk("rst_i_rdata",   i_rdata, 32'd0);

        // First cycle after reset, no requests.
        tick(); rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; d_wstrb = 4'h0; settle();
        chk("post_rst_i_data_ok", {31'd0, i_data_ok}, 32'd0);
        chk("post_rst_d_data_ok", {31'd0, d_data_ok}, 32'd0);
        chk("post_rst_sram_en",   {31'd0, sram_en}, 32'd0);

        // I only.
        tick(); i_req = 1'b1; i_addr = 32'hBFC0_0000; settle();
        chk("i_only_addr_ok",  {31'd0, i_addr_ok}, 32'd1);
        chk("i_only_d_ok",     {31'd0, d_addr_ok}, 32'd0);
        chk("i_only_sram_en",  {31'd0, sram_en}, 32'd1);
        chk("i_only_addr",     sram_addr, 32'hBFC0_0000);
        chk("i_only_wen",      {28'd0, sram_wen}, 32'd0);
        tick(); i_req = 1'b0; sram_rdata = 32'hCAFE_F00D; settle();
        chk("i_only_data_ok",  {31'd0, i_data_ok}, 32'd1);
        chk("i_only_d_data",   {31'd0, d_data_ok}, 32'd0);
        chk("i_only_rdata",    i_rdata, 32'hCAFE_F00D);
        chk("i_only_en_off",   {31'd0, sram_en}, 32'd0);

        // Idle gap after the response cycle.
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            chk("idle_sram_en",   {31'd0, sram_en}, 32'd0);
            chk("idle_sram_wen",  {28'd0, sram_wen}, 32'd0);
            chk("idle_i_data_ok", {31'd0, i_data_ok}, 32'd0);
            chk("idle_d_data_ok", {31'd0, d_data_ok}, 32'd0);
        end

        // D write.
        tick(); d_req = 1'b1; d_wr = 1'b1; d_wstrb = 4'h3;
        d_addr = 32'h8000_1000; d_wdata = 32'h1234_ABCD; settle();
        chk("dw_addr_ok",  {31'd0, d_addr_ok}, 32'd1);
        chk("dw_i_ok",     {31'd0, i_addr_ok}, 32'd0);
        chk("dw_wen",      {28'd0, sram_wen}, 32'h3);
        chk("dw_wdata",    sram_wdata, 32'h1234_ABCD);
        chk("dw_addr",     sram_addr, 32'h8000_1000);
        tick(); d_req = 1'b0; d_wr = 1'b0; d_wstrb = 4'h0; settle();
        chk("dw_data_ok",  {31'd0, d_data_ok}, 32'd1);
        chk("dw_i_data",   {31'd0, i_data_ok}, 32'd0);
        chk("dw_wen_off",  {28'd0, sram_wen}, 32'd0);

        // Back-to-back: D read at N, I read at N+1.
        tick(); d_req = 1'b1; d_addr = 32'h8000_2000; settle();
        chk("b2b_d_addr_ok", {31'd0, d_addr_ok}, 32'd1);
        chk("b2b_en_n",      {31'd0, sram_en}, 32'd1);
        chk("b2b_d_wen",     {28'd0, sram_wen}, 32'd0);
        tick(); d_req = 1'b0; i_req = 1'b1; i_addr = 32'hBFC0_0004; sram_rdata = 32'h1111_2222; settle();
        chk("b2b_d_data_ok", {31'd0, d_data_ok}, 32'd1);
        chk("b2b_d_rdata",   d_rdata, 32'h1111_2222);
        chk("b2b_i_addr_ok", {31'd0, i_addr_ok}, 32'd1);
        chk("b2b_en_n1",     {31'd0, sram_en}, 32'd1);
        chk("b2b_i_addr",    sram_addr, 32'hBFC0_0004);
        tick(); i_req = 1'b0; sram_rdata = 32'h3333_4444; settle();
        chk("b2b_i_data_ok", {31'd0, i_data_ok}, 32'd1);
        chk("b2b_d_data_n2", {31'd0, d_data_ok}, 32'd0);
        chk("b2b_i_rdata",   i_rdata, 32'h3333_4444);

        // Contention for 10 cycles.
        tick(); i_req = 1'b1; d_req = 1'b1; i_addr = 32'hBFC0_0100; d_addr = 32'h8000_0100;
        for (int k = 0; k < 10; k++) begin
            settle();
            chk("cont_d_gnt", {31'd0, d_addr_ok}, {31'd0, cont_exp[9-k]});
            chk("cont_i_gnt", {31'd0, i_addr_ok}, {31'd0, ~cont_exp[9-k]});
            chk("cont_addr",  sram_addr, cont_exp[9-k] ? 32'h8000_0100 : 32'hBFC0_0100);
            tick();
        end
        i_req = 1'b0; d_req = 1'b0; settle();
        chk("cont_last_i_data", {31'd0, i_data_ok}, 32'd1);

        // Build up starvation count (3 D grants with I waiting), then reset mid-access.
        tick(); i_req = 1'b1; d_req = 1'b1;
        tick(); tick(); tick(); rst = 1'b1; settle();
        chk("rst_mid_d_addr_ok", {31'd0, d_addr_ok}, 32'd0);
        chk("rst_mid_sram_en",   {31'd0, sram_en}, 32'd0);
        chk("rst_mid_d_data_ok", {31'd0, d_data_ok}, 32'd0);
        chk("rst_mid_d_rdata",   d_rdata, 32'd0);
        tick(); rst = 1'b0; i_req = 1'b0; d_req = 1'b0; settle();
        chk("rst_mid_no_data_ok", {31'd0, d_data_ok}, 32'd0);
        chk("rst_mid_no_i_ok",    {31'd0, i_data_ok}, 32'd0);

        // Counter must have restarted: four D grants before the forced I.
        tick(); i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("post_rst_d_gnt", {31'd0, d_addr_ok}, {31'd0, post_rst_exp[4-k]});
            chk("post_rst_i_gnt", {31'd0, i_addr_ok}, {31'd0, ~post_rst_exp[4-k]});
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
